vga_rect_fill: RTL

//  Rectangle-fill pixel engine that drives the simulator "VGA" plot port (VGA_X/VGA_Y/VGA_COLOR/plot).

---
 rtl/vga_rect_fill_pkg.sv | 16 +
 rtl/vga_raster_scan.sv | 63 ++++++
 rtl/vga_rect_fill.sv | 98 +++++++++
 3 files changed

// File: rtl/vga_rect_fill_pkg.sv
// Shared definitions for the VGA draw engines: resolution defaults and FSM state encoding.
package vga_rect_fill_pkg;

    // 640x480 resolution defaults; 320x240 uses 9/8/320/240 and 160x120 uses 8/7/160/120.
    localparam int unsigned DefXw   = 10;
    localparam int unsigned DefYw   = 9;
    localparam int unsigned DefXmax = 640;
    localparam int unsigned DefYmax = 480;
    localparam int unsigned DefCw   = 24;

    // Draw-engine state encoding, shared with the line and clear engines.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StDraw = 2'd1;
    localparam logic [1:0] StFin  = 2'd2;

endpackage

// File: rtl/vga_raster_scan.sv
// Raster-order pixel walker over [x0,xe) x [y0,ye). Bounds are captured on start_i.
module vga_raster_scan
#(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          advance_i,
    input  logic [XW-1:0] x0_i,
    input  logic [XW:0]   xe_i,
    input  logic [YW-1:0] y0_i,
    input  logic [YW:0]   ye_i,
    output logic [XW-1:0] cx_o,
    output logic [YW-1:0] cy_o,
    output logic          last_o
);

    logic [XW-1:0] x0_q, cx_q;
    logic [XW:0]   xe_q;
    logic [YW:0]   ye_q;
    logic [YW-1:0] cy_q;
    logic [XW:0]   cx_inc;
    logic [YW:0]   cy_inc;
    logic          row_end;

    // One-wider increments so the compare against an exclusive end never wraps.
    always_comb begin
        cx_inc  = {1'b0, cx_q} + {{XW{1'b0}}, 1'b1};
        cy_inc  = {1'b0, cy_q} + {{YW{1'b0}}, 1'b1};
        row_end = (cx_inc == xe_q);
        last_o  = row_end && (cy_inc == ye_q);
    end

    // Capture bounds on start, then step one pixel per advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x0_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else if (start_i) begin
            x0_q <= x0_i;
            xe_q <= xe_i;
            ye_q <= ye_i;
            cx_q <= x0_i;
            cy_q <= y0_i;
        end else if (advance_i) begin
            if (row_end) begin
                cx_q <= x0_q;
                cy_q <= cy_inc[YW-1:0];
            end else begin
                cx_q <= cx_inc[XW-1:0];
            end
        end
    end

    assign cx_o = cx_q;
    assign cy_o = cy_q;

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: accepts one clipped rectangle per handshake, emits one plot per pixel.
module vga_rect_fill
    import vga_rect_fill_pkg::*;
#(
    parameter int unsigned XW   = DefXw,
    parameter int unsigned YW   = DefYw,
    parameter int unsigned XMAX = DefXmax,
    parameter int unsigned YMAX = DefYmax,
    parameter int unsigned CW   = DefCw
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_color,
    output logic [XW-1:0] VGA_X,
    output logic [YW-1:0] VGA_Y,
    output logic [CW-1:0] VGA_COLOR,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam logic [XW:0] XLim = (XW+1)'(XMAX);
    localparam logic [YW:0] YLim = (YW+1)'(YMAX);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] color_q;
    logic [XW:0]   x_sum, xe;
    logic [YW:0]   y_sum, ye;
    logic          accept, empty_cmd, start, advance, last;

    // Clip the exclusive ends to the screen; sums are one bit wider so they never wrap.
    always_comb begin
        x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
        y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
        xe        = (x_sum > XLim) ? XLim : x_sum;
        ye        = (y_sum > YLim) ? YLim : y_sum;
        empty_cmd = (cmd_w == '0) || (cmd_h == '0) ||
                    ({1'b0, cmd_x} >= XLim) || ({1'b0, cmd_y} >= YLim);
        accept    = cmd_valid && (state_q == StIdle);
        start     = accept && !empty_cmd;
        advance   = (state_q == StDraw) && !last;
    end

    // Next-state: empty commands skip straight to the done cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = empty_cmd ? StFin : StDraw;
            StDraw:  if (last) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and fill colour; colour only changes when a visible rectangle starts.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) color_q <= cmd_color;
        end
    end

    vga_raster_scan #(
        .XW (XW),
        .YW (YW)
    ) u_scan (
        .clk_i     (CLOCK_50),
        .rst_ni    (Resetn),
        .start_i   (start),
        .advance_i (advance),
        .x0_i      (cmd_x),
        .xe_i      (xe),
        .y0_i      (cmd_y),
        .ye_i      (ye),
        .cx_o      (VGA_X),
        .cy_o      (VGA_Y),
        .last_o    (last)
    );

    // Status outputs decode the registered state; position registers hold after the draw.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        plot      = (state_q == StDraw);
        done      = (state_q == StFin);
        busy      = (state_q != StIdle);
        VGA_COLOR = color_q;
    end

endmodule
